axil_mem_arbiter: RTL and testbench

- Shares one AXI-Lite memory port between instruction fetch (read-only) and the memory read/write stage (read and write).
- Sits between the two pipeline-side masters and the cache/memory controller.
- Sequences one outstanding read at a time and tracks split AW/W acceptance.
- Blocks new reads while a store is unresolved, so a load issued after a store never overtakes it.

---
 rtl/axil_mem_arbiter_if.sv | 31 +++
 rtl/axil_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_axil_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mem_arbiter_if.sv
// AXI-Lite bundle shared by the requester and memory sides of axil_mem_arbiter.
// Read and write channels carry separate modports so one instance can serve either role.
interface axil_interface_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport rd_mst (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport rd_slv (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
  modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                  input awready, wready, bresp, bvalid);
  modport wr_slv (input awaddr, awvalid, wdata, wstrb, wvalid, bready,
                  output awready, wready, bresp, bvalid);
endinterface

// File: rtl/axil_mem_arbiter.sv
// Shares one AXI-Lite memory port between fetch reads and data-stage reads/writes.
// Define ARB_ROUND_ROBIN_EN for alternating read priority; default is data-stage fixed priority.
module axil_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  axil_interface_if.rd_slv    if_rd,
  axil_interface_if.rd_slv    dm_rd,
  axil_interface_if.wr_slv    dm_wr,
  axil_interface_if.rd_mst    mem_rd,
  axil_interface_if.wr_mst    mem_wr,
  output logic                rd_owner,
  output logic                busy
);

  typedef enum logic {R_IDLE = 1'b0, R_WAIT = 1'b1} rd_state_e;
  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic ar_lock_q, ar_lock_d;
  logic rd_owner_q, rd_owner_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic busy_q, busy_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic prio_q, prio_d;
`endif

  logic              rd_gate_open_s;
  logic              sel_s;
  logic              req_valid_s;
  logic              ar_fwd_s;
  logic              ar_hs_s;
  logic              r_hs_s;
  logic              aw_fwd_s;
  logic              w_fwd_s;
  logic              aw_hs_s;
  logic              w_hs_s;
  logic              b_hs_s;
  logic [ADDR_W-1:0] ar_addr_s;
  logic [DATA_W-1:0] rdata_s;

  // Read owner selection and AR forwarding; a held lock overrides the store gate.
  always_comb begin
    rd_gate_open_s = (wr_state_q == W_IDLE) && !aw_done_q && !w_done_q && !dm_wr.awvalid;
    if (ar_lock_q) begin
      sel_s = rd_owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    end else if (dm_rd.arvalid && if_rd.arvalid) begin
      sel_s = prio_q;
`endif
    end else begin
      sel_s = dm_rd.arvalid;
    end
    req_valid_s = sel_s ? dm_rd.arvalid : if_rd.arvalid;
    ar_addr_s   = sel_s ? dm_rd.araddr : if_rd.araddr;
    ar_fwd_s    = !rst && (rd_state_q == R_IDLE) && (ar_lock_q || rd_gate_open_s) && req_valid_s;
    ar_hs_s     = ar_fwd_s && mem_rd.arready;
    r_hs_s      = !rst && (rd_state_q == R_WAIT) && mem_rd.rvalid &&
                  (rd_owner_q ? dm_rd.rready : if_rd.rready);
  end

  // Read channel routing toward memory and requesters.
  always_comb begin
    rdata_s        = mem_rd.rdata;
    mem_rd.araddr  = ar_addr_s;
    mem_rd.arvalid = ar_fwd_s;
    if_rd.arready  = ar_hs_s && !sel_s;
    dm_rd.arready  = ar_hs_s && sel_s;
    if_rd.rdata    = rdata_s;
    dm_rd.rdata    = rdata_s;
    if_rd.rresp    = mem_rd.rresp;
    dm_rd.rresp    = mem_rd.rresp;
    if (rst) begin
      mem_rd.rready = 1'b0;
      if_rd.rvalid  = 1'b0;
      dm_rd.rvalid  = 1'b0;
    end else if (rd_state_q == R_WAIT) begin
      mem_rd.rready = rd_owner_q ? dm_rd.rready : if_rd.rready;
      if_rd.rvalid  = mem_rd.rvalid && !rd_owner_q;
      dm_rd.rvalid  = mem_rd.rvalid && rd_owner_q;
    end else begin
      // An R beat with no read in flight belongs to nobody; drain it.
      mem_rd.rready = 1'b1;
      if_rd.rvalid  = 1'b0;
      dm_rd.rvalid  = 1'b0;
    end
  end

  // Write channel pass-through with split AW/W absorption.
  always_comb begin
    aw_fwd_s       = !rst && (wr_state_q == W_IDLE) && dm_wr.awvalid && !aw_done_q;
    w_fwd_s        = !rst && (wr_state_q == W_IDLE) && dm_wr.wvalid && !w_done_q;
    aw_hs_s        = aw_fwd_s && mem_wr.awready;
    w_hs_s         = w_fwd_s && mem_wr.wready;
    b_hs_s         = !rst && (wr_state_q == W_RESP) && mem_wr.bvalid && dm_wr.bready;
    mem_wr.awaddr  = dm_wr.awaddr;
    mem_wr.awvalid = aw_fwd_s;
    mem_wr.wdata   = dm_wr.wdata;
    mem_wr.wstrb   = dm_wr.wstrb;
    mem_wr.wvalid  = w_fwd_s;
    dm_wr.bresp    = mem_wr.bresp;
    if (rst) begin
      dm_wr.awready = 1'b0;
      dm_wr.wready  = 1'b0;
      dm_wr.bvalid  = 1'b0;
      mem_wr.bready = 1'b0;
    end else if (wr_state_q == W_IDLE) begin
      dm_wr.awready = aw_done_q | mem_wr.awready;
      dm_wr.wready  = w_done_q | mem_wr.wready;
      dm_wr.bvalid  = 1'b0;
      mem_wr.bready = 1'b0;
    end else begin
      dm_wr.awready = 1'b0;
      dm_wr.wready  = 1'b0;
      dm_wr.bvalid  = mem_wr.bvalid;
      mem_wr.bready = dm_wr.bready;
    end
  end

  // Next-state logic for both FSMs and the status outputs.
  always_comb begin
    rd_state_d = rd_state_q;
    wr_state_d = wr_state_q;
    ar_lock_d  = ar_lock_q;
    rd_owner_d = rd_owner_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
`ifdef ARB_ROUND_ROBIN_EN
    prio_d     = prio_q;
`endif
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_d = R_WAIT;
          rd_owner_d = sel_s;
          ar_lock_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          prio_d     = !sel_s;
`endif
        end else if (ar_fwd_s) begin
          ar_lock_d  = 1'b1;
          rd_owner_d = sel_s;
        end else begin
          ar_lock_d  = ar_lock_q;
        end
      end
      R_WAIT: begin
        if (r_hs_s) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_state_d = R_WAIT;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    case (wr_state_q)
      W_IDLE: begin
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
          wr_state_d = W_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          aw_done_d  = aw_done_q || aw_hs_s;
          w_done_d   = w_done_q || w_hs_s;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    busy_d = (rd_state_d == R_WAIT) || (wr_state_d != W_IDLE) || aw_done_d || w_done_d;
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      ar_lock_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_q     <= 1'b1;
`endif
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      ar_lock_q  <= ar_lock_d;
      rd_owner_q <= rd_owner_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      busy_q     <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      prio_q     <= prio_d;
`endif
    end
  end

  assign rd_owner = rd_owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed self-checking bench for axil_mem_arbiter; the memory side is driven by hand.
module tb_axil_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_owner;
  logic busy;
  int checks = 0;
  int errors = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;

  always #5 clk = ~clk;

  axil_interface_if #(.ADDR_W(64), .DATA_W(64)) if_bus ();
  axil_interface_if #(.ADDR_W(64), .DATA_W(64)) dm_bus ();
  axil_interface_if #(.ADDR_W(64), .DATA_W(64)) mem_bus ();

  axil_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_rd(if_bus), .dm_rd(dm_bus), .dm_wr(dm_bus),
    .mem_rd(mem_bus), .mem_wr(mem_bus),
    .rd_owner(rd_owner), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_bus.awvalid && mem_bus.awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (mem_bus.wvalid && mem_bus.wready) w_hs_cnt <= w_hs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_bus.araddr = 64'h0; if_bus.arvalid = 1'b0; if_bus.rready = 1'b0;
    if_bus.awaddr = 64'h0; if_bus.awvalid = 1'b0; if_bus.wdata = 64'h0;
    if_bus.wstrb = 8'h0; if_bus.wvalid = 1'b0; if_bus.bready = 1'b0;
    dm_bus.araddr = 64'h0; dm_bus.arvalid = 1'b0; dm_bus.rready = 1'b0;
    dm_bus.awaddr = 64'h0; dm_bus.awvalid = 1'b0; dm_bus.wdata = 64'h0;
    dm_bus.wstrb = 8'h0; dm_bus.wvalid = 1'b0; dm_bus.bready = 1'b0;
    mem_bus.arready = 1'b0; mem_bus.rdata = 64'h0; mem_bus.rresp = 2'b00; mem_bus.rvalid = 1'b0;
    mem_bus.awready = 1'b0; mem_bus.wready = 1'b0; mem_bus.bresp = 2'b00; mem_bus.bvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    if_bus.arvalid = 1'b1; if_bus.araddr = 64'h10; mem_bus.arready = 1'b1; mem_bus.rvalid = 1'b1;
    dm_bus.awvalid = 1'b1; dm_bus.wvalid = 1'b1; mem_bus.awready = 1'b1; mem_bus.wready = 1'b1;
    tick();
    tick();
    checks++; if (mem_bus.arvalid !== 1'b0) begin errors++; $display("FAIL reset_mem_arvalid: got %0b expected 0", mem_bus.arvalid); end
    checks++; if (if_bus.arready !== 1'b0) begin errors++; $display("FAIL reset_if_arready: got %0b expected 0", if_bus.arready); end
    checks++; if (mem_bus.awvalid !== 1'b0 || mem_bus.wvalid !== 1'b0) begin errors++; $display("FAIL reset_mem_aw_w_valid: got %0b%0b expected 00", mem_bus.awvalid, mem_bus.wvalid); end
    checks++; if (dm_bus.awready !== 1'b0 || dm_bus.wready !== 1'b0) begin errors++; $display("FAIL reset_dm_aw_w_ready: got %0b%0b expected 00", dm_bus.awready, dm_bus.wready); end
    checks++; if (dm_bus.rvalid !== 1'b0 || if_bus.rvalid !== 1'b0 || dm_bus.bvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid_bvalid: got %0b%0b%0b expected 000", dm_bus.rvalid, if_bus.rvalid, dm_bus.bvalid); end
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++; if (rd_owner !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_owner_busy: got %0b%0b expected 00", rd_owner, busy); end
  endtask

  task automatic test_priority();
    do_reset();
    if_bus.araddr = 64'h1000; if_bus.arvalid = 1'b1;
    dm_bus.araddr = 64'h2008; dm_bus.arvalid = 1'b1;
    mem_bus.arready = 1'b1;
    #1;
    checks++; if (mem_bus.araddr !== 64'h2008) begin errors++; $display("FAIL prio_first_addr: got %0h expected 2008", mem_bus.araddr); end
    checks++; if (dm_bus.arready !== 1'b1 || if_bus.arready !== 1'b0) begin errors++; $display("FAIL prio_first_arready: got dm=%0b if=%0b expected dm=1 if=0", dm_bus.arready, if_bus.arready); end
    tick();
    dm_bus.arvalid = 1'b0;
    #1;
    checks++; if (rd_owner !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL prio_owner_busy: got %0b%0b expected 11", rd_owner, busy); end
    checks++; if (mem_bus.arvalid !== 1'b0 || if_bus.arready !== 1'b0) begin errors++; $display("FAIL prio_wait_no_ar: got arvalid=%0b if_arready=%0b expected 0 0", mem_bus.arvalid, if_bus.arready); end
    tick();
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'h1111; dm_bus.rready = 1'b1; if_bus.rready = 1'b1;
    #1;
    checks++; if (dm_bus.rvalid !== 1'b1 || if_bus.rvalid !== 1'b0 || dm_bus.rdata !== 64'h1111) begin errors++; $display("FAIL prio_r_to_data: got dm=%0b if=%0b data=%0h expected 1 0 1111", dm_bus.rvalid, if_bus.rvalid, dm_bus.rdata); end
    tick();
    mem_bus.rvalid = 1'b0;
    #1;
    checks++; if (mem_bus.araddr !== 64'h1000 || if_bus.arready !== 1'b1) begin errors++; $display("FAIL prio_fetch_next: got addr=%0h arready=%0b expected 1000 1", mem_bus.araddr, if_bus.arready); end
    tick();
    if_bus.arvalid = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'h2222;
    #1;
    checks++; if (rd_owner !== 1'b0 || if_bus.rvalid !== 1'b1 || dm_bus.rvalid !== 1'b0) begin errors++; $display("FAIL prio_fetch_r: got owner=%0b if=%0b dm=%0b expected 0 1 0", rd_owner, if_bus.rvalid, dm_bus.rvalid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_own;
    do_reset();
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = (r % 2 == 0) ? 1'b1 : 1'b0;
`else
      exp_own = 1'b1;
`endif
      if_bus.araddr = 64'h1000; if_bus.arvalid = 1'b1;
      dm_bus.araddr = 64'h2008; dm_bus.arvalid = 1'b1;
      mem_bus.arready = 1'b1;
      #1;
      checks++; if (mem_bus.araddr !== (exp_own ? 64'h2008 : 64'h1000)) begin errors++; $display("FAIL rr_addr round %0d: got %0h expected owner %0b", r, mem_bus.araddr, exp_own); end
      tick();
      checks++; if (rd_owner !== exp_own) begin errors++; $display("FAIL rr_owner round %0d: got %0b expected %0b", r, rd_owner, exp_own); end
      if (exp_own) dm_bus.arvalid = 1'b0; else if_bus.arvalid = 1'b0;
      mem_bus.rvalid = 1'b1; dm_bus.rready = 1'b1; if_bus.rready = 1'b1;
      tick();
      mem_bus.rvalid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_store_load();
    do_reset();
    mem_bus.awready = 1'b1; mem_bus.wready = 1'b1;
    dm_bus.awaddr = 64'h40; dm_bus.awvalid = 1'b1;
    dm_bus.wdata = 64'hDEADBEEF; dm_bus.wstrb = 8'h0F; dm_bus.wvalid = 1'b1; dm_bus.bready = 1'b1;
    #1;
    checks++; if (mem_bus.awvalid !== 1'b1 || mem_bus.wdata !== 64'hDEADBEEF || mem_bus.wstrb !== 8'h0F) begin errors++; $display("FAIL st_fwd: got awvalid=%0b wdata=%0h wstrb=%0h expected 1 deadbeef 0f", mem_bus.awvalid, mem_bus.wdata, mem_bus.wstrb); end
    tick();
    dm_bus.awvalid = 1'b0; dm_bus.wvalid = 1'b0;
    dm_bus.araddr = 64'h40; dm_bus.arvalid = 1'b1; dm_bus.rready = 1'b1; mem_bus.arready = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL st_busy: got %0b expected 1", busy); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (mem_bus.arvalid !== 1'b0 || dm_bus.arready !== 1'b0) begin errors++; $display("FAIL st_load_blocked cycle %0d: got arvalid=%0b arready=%0b expected 0 0", c, mem_bus.arvalid, dm_bus.arready); end
      tick();
    end
    mem_bus.bvalid = 1'b1; mem_bus.bresp = 2'b00;
    #1;
    checks++; if (dm_bus.bvalid !== 1'b1 || mem_bus.arvalid !== 1'b0) begin errors++; $display("FAIL st_b_cycle: got bvalid=%0b arvalid=%0b expected 1 0", dm_bus.bvalid, mem_bus.arvalid); end
    tick();
    mem_bus.bvalid = 1'b0;
    #1;
    checks++; if (mem_bus.arvalid !== 1'b1 || mem_bus.araddr !== 64'h40) begin errors++; $display("FAIL st_load_released: got arvalid=%0b addr=%0h expected 1 40", mem_bus.arvalid, mem_bus.araddr); end
    tick();
    dm_bus.arvalid = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'hDEADBEEF;
    #1;
    checks++; if (dm_bus.rvalid !== 1'b1 || dm_bus.rdata !== 64'hDEADBEEF) begin errors++; $display("FAIL st_load_data: got rvalid=%0b data=%0h expected 1 deadbeef", dm_bus.rvalid, dm_bus.rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_split_write();
    int aw0;
    int w0;
    do_reset();
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    dm_bus.awaddr = 64'h88; dm_bus.awvalid = 1'b1;
    dm_bus.wdata = 64'h55; dm_bus.wstrb = 8'hFF; dm_bus.wvalid = 1'b1; dm_bus.bready = 1'b1;
    tick();
    checks++; if (dm_bus.awready !== 1'b0 || dm_bus.wready !== 1'b0) begin errors++; $display("FAIL sw_c1_ready: got %0b%0b expected 00", dm_bus.awready, dm_bus.wready); end
    tick();
    mem_bus.awready = 1'b1;
    #1;
    checks++; if (dm_bus.awready !== 1'b1 || mem_bus.awvalid !== 1'b1 || dm_bus.wready !== 1'b0) begin errors++; $display("FAIL sw_c2_aw: got awready=%0b awvalid=%0b wready=%0b expected 1 1 0", dm_bus.awready, mem_bus.awvalid, dm_bus.wready); end
    tick();
    checks++; if (mem_bus.awvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sw_c3_absorbed: got awvalid=%0b busy=%0b expected 0 1", mem_bus.awvalid, busy); end
    tick();
    tick();
    mem_bus.wready = 1'b1;
    #1;
    checks++; if (dm_bus.wready !== 1'b1 || mem_bus.wvalid !== 1'b1) begin errors++; $display("FAIL sw_c5_w: got wready=%0b wvalid=%0b expected 1 1", dm_bus.wready, mem_bus.wvalid); end
    tick();
    dm_bus.awvalid = 1'b0; dm_bus.wvalid = 1'b0;
    #1;
    checks++; if (dm_bus.awready !== 1'b0 || dm_bus.wready !== 1'b0 || mem_bus.bready !== 1'b1) begin errors++; $display("FAIL sw_resp_state: got awready=%0b wready=%0b bready=%0b expected 0 0 1", dm_bus.awready, dm_bus.wready, mem_bus.bready); end
    checks++; if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin errors++; $display("FAIL sw_hs_count: got aw=%0d w=%0d expected 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0); end
    mem_bus.bvalid = 1'b1; mem_bus.bresp = 2'b10;
    #1;
    checks++; if (dm_bus.bvalid !== 1'b1 || dm_bus.bresp !== 2'b10) begin errors++; $display("FAIL sw_bresp: got bvalid=%0b bresp=%0b expected 1 10", dm_bus.bvalid, dm_bus.bresp); end
    tick();
    mem_bus.bvalid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_idle_busy: got %0b expected 0", busy); end
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    if_bus.araddr = 64'h80; if_bus.arvalid = 1'b1; if_bus.rready = 1'b1;
    #1;
    checks++; if (mem_bus.araddr !== 64'h80 || mem_bus.arvalid !== 1'b1) begin errors++; $display("FAIL lock_c0: got addr=%0h arvalid=%0b expected 80 1", mem_bus.araddr, mem_bus.arvalid); end
    tick();
    dm_bus.araddr = 64'h2008; dm_bus.arvalid = 1'b1; dm_bus.rready = 1'b1;
    #1;
    checks++; if (mem_bus.araddr !== 64'h80 || dm_bus.arready !== 1'b0) begin errors++; $display("FAIL lock_c1: got addr=%0h dm_arready=%0b expected 80 0", mem_bus.araddr, dm_bus.arready); end
    tick();
    checks++; if (mem_bus.araddr !== 64'h80) begin errors++; $display("FAIL lock_c2: got addr=%0h expected 80", mem_bus.araddr); end
    tick();
    mem_bus.arready = 1'b1;
    #1;
    checks++; if (mem_bus.araddr !== 64'h80 || if_bus.arready !== 1'b1 || dm_bus.arready !== 1'b0) begin errors++; $display("FAIL lock_c3_hs: got addr=%0h if=%0b dm=%0b expected 80 1 0", mem_bus.araddr, if_bus.arready, dm_bus.arready); end
    tick();
    if_bus.arvalid = 1'b0;
    mem_bus.rvalid = 1'b1;
    tick();
    mem_bus.rvalid = 1'b0;
    #1;
    checks++; if (mem_bus.araddr !== 64'h2008 || dm_bus.arready !== 1'b1) begin errors++; $display("FAIL lock_data_after: got addr=%0h dm_arready=%0b expected 2008 1", mem_bus.araddr, dm_bus.arready); end
    tick();
    dm_bus.arvalid = 1'b0;
    checks++; if (rd_owner !== 1'b1) begin errors++; $display("FAIL lock_data_owner: got %0b expected 1", rd_owner); end
    mem_bus.rvalid = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    if_bus.araddr = 64'h100; if_bus.arvalid = 1'b1; mem_bus.arready = 1'b1;
    tick();
    if_bus.arvalid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (mem_bus.arvalid !== 1'b0 || if_bus.rvalid !== 1'b0) begin errors++; $display("FAIL rmr_in_reset: got arvalid=%0b rvalid=%0b expected 0 0", mem_bus.arvalid, if_bus.rvalid); end
    tick();
    tick();
    rst = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'hBAD;
    #1;
    checks++; if (if_bus.rvalid !== 1'b0 || dm_bus.rvalid !== 1'b0 || mem_bus.rready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmr_stale_r: got if=%0b dm=%0b rready=%0b busy=%0b expected 0 0 1 0", if_bus.rvalid, dm_bus.rvalid, mem_bus.rready, busy); end
    tick();
    mem_bus.rvalid = 1'b0;
    if_bus.araddr = 64'h200; if_bus.arvalid = 1'b1;
    #1;
    checks++; if (mem_bus.arvalid !== 1'b1 || if_bus.arready !== 1'b1 || mem_bus.araddr !== 64'h200) begin errors++; $display("FAIL rmr_new_ar: got arvalid=%0b arready=%0b addr=%0h expected 1 1 200", mem_bus.arvalid, if_bus.arready, mem_bus.araddr); end
    tick();
    if_bus.arvalid = 1'b0;
    checks++; if (busy !== 1'b1 || rd_owner !== 1'b0) begin errors++; $display("FAIL rmr_busy_owner: got %0b%0b expected 10", busy, rd_owner); end
    if_bus.rready = 1'b1; mem_bus.rvalid = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dm_bus.araddr = 64'h300; dm_bus.arvalid = 1'b1; mem_bus.arready = 1'b1;
    tick();
    dm_bus.araddr = 64'h308;
    mem_bus.rvalid = 1'b1; dm_bus.rready = 1'b1;
    #1;
    checks++; if (dm_bus.rvalid !== 1'b1 || mem_bus.arvalid !== 1'b0 || dm_bus.arready !== 1'b0) begin errors++; $display("FAIL b2b_same_cycle: got rvalid=%0b arvalid=%0b arready=%0b expected 1 0 0", dm_bus.rvalid, mem_bus.arvalid, dm_bus.arready); end
    tick();
    mem_bus.rvalid = 1'b0;
    #1;
    checks++; if (mem_bus.arvalid !== 1'b1 || mem_bus.araddr !== 64'h308) begin errors++; $display("FAIL b2b_next_cycle: got arvalid=%0b addr=%0h expected 1 308", mem_bus.arvalid, mem_bus.araddr); end
    tick();
    dm_bus.arvalid = 1'b0;
    mem_bus.rvalid = 1'b1;
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_priority();
    test_round_robin();
    test_store_load();
    test_split_write();
    test_lock();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
